// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file write-back stage.
package wb_pkg;

    localparam int unsigned REG_ADDR_W       = 5;
    localparam int unsigned XLEN             = 32;
    localparam int unsigned FIFO_DEPTH_DEF   = 4;
    localparam int unsigned STARVE_LIMIT_DEF = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage : wb_pkg

// File: rtl/writeback_arbiter_if.sv
// Write-back bus: ALU and slow-path result inputs, register-file write port, status.
// Forwarding signals exist only when WB_FWD_EN is defined.
interface writeback_arbiter_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    import wb_pkg::*;

    logic                      alu_valid;
    logic [REG_ADDR_W-1:0]     alu_rd;
    logic [XLEN-1:0]           alu_data;
    logic                      mem_valid;
    logic                      mem_ready;
    logic [REG_ADDR_W-1:0]     mem_rd;
    logic [XLEN-1:0]           mem_data;
    logic                      stall_alu;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      we;
    logic [REG_ADDR_W-1:0]     wr;
    logic [XLEN-1:0]           wd;
`ifdef WB_FWD_EN
    logic [REG_ADDR_W-1:0]     rr1;
    logic [REG_ADDR_W-1:0]     rr2;
    logic                      fwd1_hit;
    logic                      fwd2_hit;
    logic [XLEN-1:0]           fwd1_data;
    logic [XLEN-1:0]           fwd2_data;
`endif

    // Producer / consumer side (execute units, register file, decode)
    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  mem_ready, stall_alu, fifo_count, we, wr, wd
`ifdef WB_FWD_EN
        , output rr1, rr2
        , input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
`endif
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output mem_ready, stall_alu, fifo_count, we, wr, wd
`ifdef WB_FWD_EN
        , input  rr1, rr2
        , output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
`endif
    );

endinterface : writeback_arbiter_if

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries; DEPTH must be a power of two (>=2).
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  wb_entry_t        din,
    output wb_entry_t        dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule : wb_fifo

// File: rtl/writeback_arbiter.sv
// Register-file write-back: ALU results win, slow-path results queue in a FIFO,
// starvation of the FIFO raises a one-cycle ALU stall. Optional bypass: WB_FWD_EN.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic                clk,
    input logic                rst,
    writeback_arbiter_if.slave bus
);

    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t             head;
    wb_entry_t             tail_in;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  push_c;
    logic                  pop_c;

    logic                  we_q,     we_n;
    logic [REG_ADDR_W-1:0] wr_q,     wr_n;
    logic [XLEN-1:0]       wd_q,     wd_n;
    logic [STARVE_W-1:0]   starve_q, starve_n;
    logic                  stall_q,  stall_n;

    // x0 results are accepted from the slow path but never stored
    assign tail_in = '{rd: bus.mem_rd, data: bus.mem_data};
    assign push_c  = bus.mem_valid && !fifo_full && (bus.mem_rd != '0);
    assign pop_c   = !bus.alu_valid && !fifo_empty;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .din   (tail_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Arbitration and starve counter next state
    always_comb begin
        we_n     = 1'b0;
        wr_n     = wr_q;
        wd_n     = wd_q;
        starve_n = '0;
        stall_n  = 1'b0;
        if (bus.alu_valid) begin
            we_n = (bus.alu_rd != '0);
            wr_n = bus.alu_rd;
            wd_n = bus.alu_data;
        end else if (!fifo_empty) begin
            we_n = 1'b1;
            wr_n = head.rd;
            wd_n = head.data;
        end
        if (bus.alu_valid && !fifo_empty) begin
            if (starve_q == STARVE_W'(STARVE_LIMIT - 1)) stall_n = 1'b1;
            else                                         starve_n = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            wr_q     <= '0;
            wd_q     <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            we_q     <= we_n;
            wr_q     <= wr_n;
            wd_q     <= wd_n;
            starve_q <= starve_n;
            stall_q  <= stall_n;
        end
    end

    // Ready depends only on occupancy, never on the same-cycle pop
    assign bus.mem_ready  = !fifo_full;
    assign bus.fifo_count = fifo_count;
    assign bus.stall_alu  = stall_q;
    assign bus.we         = we_q;
    assign bus.wr         = wr_q;
    assign bus.wd         = wd_q;

`ifdef WB_FWD_EN
    // Bypass for decode: the file returns this write one cycle late
    assign bus.fwd1_hit  = we_q && (wr_q != '0) && (wr_q == bus.rr1);
    assign bus.fwd2_hit  = we_q && (wr_q != '0) && (wr_q == bus.rr2);
    assign bus.fwd1_data = wd_q;
    assign bus.fwd2_data = wd_q;
`endif

endmodule : writeback_arbiter

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: vector table, write scoreboard, starvation and reset sequences.
`timescale 1ns/1ps
module tb_writeback_arbiter;
    import wb_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

    writeback_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        ewe;
        logic [4:0]  ewr;
        logic [31:0] ewd;
        int unsigned ecnt;
    } vec_t;

    int        errors = 0;
    int        checks = 0;
    wb_entry_t m_q [$];
    wb_entry_t sb  [$];
    int        m_starve = 0;
    logic      m_stall  = 1'b0;
    logic      m_we     = 1'b0;
    vec_t      tbl [19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int unsigned av, input int unsigned ard, input logic [31:0] ad,
                                input int unsigned mv, input int unsigned mrd, input logic [31:0] md,
                                input int unsigned ewe, input int unsigned ewr, input logic [31:0] ewd,
                                input int unsigned ecnt);
        vec_t v;
        v.av = 1'(av);   v.ard = 5'(ard); v.ad = ad;
        v.mv = 1'(mv);   v.mrd = 5'(mrd); v.md = md;
        v.ewe = 1'(ewe); v.ewr = 5'(ewr); v.ewd = ewd;
        v.ecnt = ecnt;
        return v;
    endfunction

    // Drive one cycle, predict its write into the scoreboard, compare after the edge
    task automatic cycle(input int unsigned av, input int unsigned ard, input logic [31:0] ad,
                         input int unsigned mv, input int unsigned mrd, input logic [31:0] md);
        bit        pre_ne;
        bit        acc;
        wb_entry_t e;
        bus.alu_valid = 1'(av);
        bus.alu_rd    = 5'(ard);
        bus.alu_data  = ad;
        bus.mem_valid = 1'(mv);
        bus.mem_rd    = 5'(mrd);
        bus.mem_data  = md;
        pre_ne = (m_q.size() != 0);
        acc    = (mv != 0) && (m_q.size() < DEPTH);
        m_we   = 1'b0;
        if (av != 0) begin
            if (ard != 0) begin
                m_we = 1'b1;
                sb.push_back(wb_entry_t'{rd: 5'(ard), data: ad});
            end
        end else if (pre_ne) begin
            m_we = 1'b1;
            sb.push_back(m_q.pop_front());
        end
        if (acc && mrd != 0) m_q.push_back(wb_entry_t'{rd: 5'(mrd), data: md});
        if (pre_ne && av != 0) begin
            m_starve++;
            if (m_starve == LIMIT) begin m_stall = 1'b1; m_starve = 0; end
            else m_stall = 1'b0;
        end else begin
            m_starve = 0;
            m_stall  = 1'b0;
        end
        @(posedge clk);
        #1;
        check("we", 64'(bus.we), 64'(m_we));
        if (bus.we === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: unexpected write wr=%0d wd=0x%0h", bus.wr, bus.wd);
            end else begin
                e = sb.pop_front();
                check("sb_wr", 64'(bus.wr), 64'(e.rd));
                check("sb_wd", 64'(bus.wd), 64'(e.data));
            end
        end else if (m_we) begin
            void'(sb.pop_front());
        end
        check("fifo_count", 64'(bus.fifo_count), 64'(m_q.size()));
        check("mem_ready", 64'(bus.mem_ready), 64'(m_q.size() < DEPTH));
        check("stall_alu", 64'(bus.stall_alu), 64'(m_stall));
    endtask

    // Upstream must not present an ALU result while stalled
    always @(negedge clk) begin
        if (!rst) assert (!(bus.stall_alu && bus.alu_valid))
            else $error("FAIL protocol: alu_valid high during stall_alu");
    end

    initial begin
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
`ifdef WB_FWD_EN
        bus.rr1 = '0; bus.rr2 = '0;
`endif
        tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0,   1, 5, 32'hDEADBEEF, 0);
        tbl[1]  = mk(1, 0, 32'h11111111, 0, 0, 32'h0,   0, 0, 32'h11111111, 0);
        tbl[2]  = mk(0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 32'h11111111, 0);
        tbl[3]  = mk(1, 10, 32'hA0,      1, 1, 32'h100, 1, 10, 32'hA0, 1);
        tbl[4]  = mk(1, 11, 32'hA1,      1, 2, 32'h101, 1, 11, 32'hA1, 2);
        tbl[5]  = mk(1, 12, 32'hA2,      1, 3, 32'h102, 1, 12, 32'hA2, 3);
        tbl[6]  = mk(1, 13, 32'hA3,      1, 4, 32'h103, 1, 13, 32'hA3, 4);
        tbl[7]  = mk(0, 0, 32'h0,        1, 20, 32'h200, 1, 1, 32'h100, 3);
        tbl[8]  = mk(0, 0, 32'h0,        0, 0, 32'h0,   1, 2, 32'h101, 2);
        tbl[9]  = mk(0, 0, 32'h0,        0, 0, 32'h0,   1, 3, 32'h102, 1);
        tbl[10] = mk(0, 0, 32'h0,        0, 0, 32'h0,   1, 4, 32'h103, 0);
        tbl[11] = mk(1, 6, 32'h66,       1, 7, 32'h77,  1, 6, 32'h66, 1);
        tbl[12] = mk(0, 0, 32'h0,        0, 0, 32'h0,   1, 7, 32'h77, 0);
        tbl[13] = mk(1, 8, 32'h88,       1, 2, 32'h202, 1, 8, 32'h88, 1);
        tbl[14] = mk(1, 9, 32'h99,       1, 3, 32'h203, 1, 9, 32'h99, 2);
        tbl[15] = mk(0, 0, 32'h0,        1, 4, 32'h204, 1, 2, 32'h202, 2);
        tbl[16] = mk(0, 0, 32'h0,        1, 0, 32'h999, 1, 3, 32'h203, 1);
        tbl[17] = mk(0, 0, 32'h0,        0, 0, 32'h0,   1, 4, 32'h204, 0);
        tbl[18] = mk(0, 0, 32'h0,        0, 0, 32'h0,   0, 4, 32'h204, 0);

        // Reset state
        #3;
        check("rst_we", 64'(bus.we), 64'(0));
        check("rst_stall", 64'(bus.stall_alu), 64'(0));
        check("rst_count", 64'(bus.fifo_count), 64'(0));
        check("rst_ready", 64'(bus.mem_ready), 64'(1));
        check("rst_wd", 64'(bus.wd), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Vector table: ALU-only, fill/drain, simultaneous push/pop, x0 drop
        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].mv, tbl[i].mrd, tbl[i].md);
            check($sformatf("tbl%0d_we", i), 64'(bus.we), 64'(tbl[i].ewe));
            check($sformatf("tbl%0d_wr", i), 64'(bus.wr), 64'(tbl[i].ewr));
            check($sformatf("tbl%0d_wd", i), 64'(bus.wd), 64'(tbl[i].ewd));
            check($sformatf("tbl%0d_cnt", i), 64'(bus.fifo_count), 64'(tbl[i].ecnt));
        end

        // Starvation: one buffered entry, ALU busy for LIMIT cycles
        cycle(1, 12, 32'hC0, 1, 15, 32'hF0);
        for (int i = 1; i <= LIMIT; i++) begin
            cycle(1, 12, 32'hC0 + 32'(i), 0, 0, 32'h0);
            check($sformatf("starve%0d_stall", i), 64'(bus.stall_alu), 64'(i == LIMIT));
        end
        cycle(0, 0, 32'h0, 0, 0, 32'h0);
        check("starve_pop_wr", 64'(bus.wr), 64'(15));
        check("starve_pop_wd", 64'(bus.wd), 64'(32'hF0));
        check("starve_stall_drop", 64'(bus.stall_alu), 64'(0));

        // Reset in the middle of a cycle with buffered entries and a write in flight
        cycle(1, 20, 32'h20, 1, 21, 32'h21);
        cycle(1, 22, 32'h22, 1, 23, 32'h23);
        #3 rst = 1'b1;
        #1;
        check("mrst_we", 64'(bus.we), 64'(0));
        check("mrst_stall", 64'(bus.stall_alu), 64'(0));
        check("mrst_count", 64'(bus.fifo_count), 64'(0));
        check("mrst_ready", 64'(bus.mem_ready), 64'(1));
        m_q.delete();
        sb.delete();
        m_starve = 0;
        m_stall  = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(0, 0, 32'h0, 0, 0, 32'h0);
        check("mrst_lost_we", 64'(bus.we), 64'(0));

`ifdef WB_FWD_EN
        // Bypass of the write in progress
        cycle(1, 9, 32'h1234, 0, 0, 32'h0);
        bus.rr1 = 5'd9;
        bus.rr2 = 5'd0;
        #1;
        check("fwd1_hit", 64'(bus.fwd1_hit), 64'(1));
        check("fwd1_data", 64'(bus.fwd1_data), 64'(32'h1234));
        check("fwd2_hit", 64'(bus.fwd2_hit), 64'(0));
        bus.rr1 = 5'd3;
        bus.rr2 = 5'd9;
        #1;
        check("fwd1_miss", 64'(bus.fwd1_hit), 64'(0));
        check("fwd2_hit9", 64'(bus.fwd2_hit), 64'(1));
        cycle(0, 0, 32'h0, 0, 0, 32'h0);
        check("fwd_idle", 64'(bus.fwd2_hit), 64'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_writeback_arbiter
